// File: rtl/dr_ald_pipe.sv
// -----------------------------------------------------------------------------
// dr_ald_pipe
// Dynamic-range approximate logarithmic divider (DR-ALD). Produces q ~= a/b as
// a signed fixed-point quotient (value = o_q / 2^FRAC_BITS). This is the inverse
// datapath of the DR-ALM multiplier core.
//
// Datapath:
//   S1  sign, exact magnitudes, leading-one position k, truncated fraction
//       x = {KEEP_WIDTH-1 bits after the leading one, 1'b1}, zero flags
//   S2  log subtraction kd = ka - kb, xd = xa - xb with borrow into kd
//   S3  antilog: mantissa 1.xd shifted by kd + FRAC_BITS - KEEP_WIDTH, signed
//
// Register ranks: operand capture -> S1 -> S2 -> S3/output. An op accepted at
// edge N is presented on o_valid at edge N+3. The whole pipe advances together
// (adv = !o_valid || i_ready); empty slots are not compressed.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_valid / o_ready    input handshake (o_ready = adv)
//   i_a, i_b             signed dividend / divisor, WIDTH bits
//   i_tag                sideband tag, returned unchanged on o_tag
//   o_valid / i_ready    output handshake
//   o_q                  signed quotient, WIDTH+FRAC_BITS+1 bits
//   o_dz                 divide-by-zero flag for this result
//   o_tag                tag of this result
// -----------------------------------------------------------------------------
module dr_ald_pipe #(
    parameter int WIDTH      = 16,
    parameter int KEEP_WIDTH = 6,
    parameter int FRAC_BITS  = 8,
    parameter int TAG_W      = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [WIDTH-1:0]           i_a,
    input  logic [WIDTH-1:0]           i_b,
    input  logic [TAG_W-1:0]           i_tag,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH+FRAC_BITS:0]   o_q,
    output logic                       o_dz,
    output logic [TAG_W-1:0]           o_tag
);
    localparam int T    = KEEP_WIDTH;
    localparam int KW   = $clog2(WIDTH);
    localparam int KD_W = KW + 2;
    localparam int QW   = WIDTH + FRAC_BITS + 1;

    // Two's-complement magnitude as unsigned; the most negative value maps to
    // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
    endfunction

    function automatic logic [KW-1:0] lod(input logic [WIDTH-1:0] v);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) k = KW'(i);
        end
        return k;
    endfunction

    // Normalise so the leading one sits at the MSB, keep T-1 bits below it and
    // force a trailing '1' to centre the truncation error.
    function automatic logic [T-1:0] frac_of(input logic [WIDTH-1:0] m,
                                             input logic [KW-1:0]    k);
        logic [WIDTH-1:0] norm;
        norm = m << (WIDTH - 1 - int'(k));
        return {norm[WIDTH-2 -: T-1], 1'b1};
    endfunction

    logic adv;

    // rank 0: operand capture
    logic             r0_vld_q;
    logic [WIDTH-1:0] r0_a_q;
    logic [WIDTH-1:0] r0_b_q;
    logic [TAG_W-1:0] r0_tag_q;

    // rank 1: S1 results
    logic             r1_vld_q;
    logic             r1_s_q,  r1_s_d;
    logic             r1_za_q, r1_za_d;
    logic             r1_zb_q, r1_zb_d;
    logic [KW-1:0]    r1_ka_q, r1_ka_d;
    logic [KW-1:0]    r1_kb_q, r1_kb_d;
    logic [T-1:0]     r1_xa_q, r1_xa_d;
    logic [T-1:0]     r1_xb_q, r1_xb_d;
    logic [TAG_W-1:0] r1_tag_q;

    // rank 2: S2 results
    logic                   r2_vld_q;
    logic                   r2_s_q;
    logic                   r2_za_q;
    logic                   r2_zb_q;
    logic signed [KD_W-1:0] r2_kd_q, r2_kd_d;
    logic [T-1:0]           r2_xd_q, r2_xd_d;
    logic [TAG_W-1:0]       r2_tag_q;

    // rank 3: output
    logic             out_vld_q;
    logic [QW-1:0]    out_q_q, out_q_d;
    logic             out_dz_q, out_dz_d;
    logic [TAG_W-1:0] out_tag_q;

    // S1
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        mag_a   = abs_mag(r0_a_q);
        mag_b   = abs_mag(r0_b_q);
        r1_s_d  = r0_a_q[WIDTH-1] ^ r0_b_q[WIDTH-1];
        r1_za_d = (r0_a_q == '0);
        r1_zb_d = (r0_b_q == '0);
        r1_ka_d = lod(mag_a);
        r1_kb_d = lod(mag_b);
        r1_xa_d = frac_of(mag_a, r1_ka_d);
        r1_xb_d = frac_of(mag_b, r1_kb_d);
    end

    // S2
    logic signed [KD_W-1:0] kd_raw;
    logic signed [T:0]      xd_raw;

    always_comb begin
        kd_raw  = $signed({2'b00, r1_ka_q}) - $signed({2'b00, r1_kb_q});
        xd_raw  = $signed({1'b0, r1_xa_q}) - $signed({1'b0, r1_xb_q});
        // Borrow adds 2^T to a (T+1)-bit negative value: only bit T changes,
        // so the low T bits are already the corrected fraction.
        r2_kd_d = xd_raw[T] ? (kd_raw - KD_W'(1)) : kd_raw;
        r2_xd_d = xd_raw[T-1:0];
    end

    // S3
    logic [QW-1:0] m_ext;
    logic [QW-1:0] mag;
    int            sh;

    always_comb begin
        m_ext = QW'({1'b1, r2_xd_q});
        sh    = int'(r2_kd_q) + FRAC_BITS - T;
        if (sh >= 0) mag = m_ext << sh;
        else         mag = m_ext >> (-sh);
        out_dz_d = r2_zb_q;
        // mag == 0 negates to 0, so no negative zero can appear.
        if (r2_za_q || r2_zb_q) out_q_d = '0;
        else if (r2_s_q)        out_q_d = -mag;
        else                    out_q_d = mag;
    end

    assign adv     = !out_vld_q || i_ready;
    assign o_ready = adv;
    assign o_valid = out_vld_q;
    assign o_q     = out_q_q;
    assign o_dz    = out_dz_q;
    assign o_tag   = out_tag_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r0_vld_q  <= 1'b0;
            r0_a_q    <= '0;
            r0_b_q    <= '0;
            r0_tag_q  <= '0;
            r1_vld_q  <= 1'b0;
            r1_s_q    <= 1'b0;
            r1_za_q   <= 1'b0;
            r1_zb_q   <= 1'b0;
            r1_ka_q   <= '0;
            r1_kb_q   <= '0;
            r1_xa_q   <= '0;
            r1_xb_q   <= '0;
            r1_tag_q  <= '0;
            r2_vld_q  <= 1'b0;
            r2_s_q    <= 1'b0;
            r2_za_q   <= 1'b0;
            r2_zb_q   <= 1'b0;
            r2_kd_q   <= '0;
            r2_xd_q   <= '0;
            r2_tag_q  <= '0;
            out_vld_q <= 1'b0;
            out_q_q   <= '0;
            out_dz_q  <= 1'b0;
            out_tag_q <= '0;
        end else if (adv) begin
            r0_vld_q  <= i_valid;
            r0_a_q    <= i_a;
            r0_b_q    <= i_b;
            r0_tag_q  <= i_tag;
            r1_vld_q  <= r0_vld_q;
            r1_s_q    <= r1_s_d;
            r1_za_q   <= r1_za_d;
            r1_zb_q   <= r1_zb_d;
            r1_ka_q   <= r1_ka_d;
            r1_kb_q   <= r1_kb_d;
            r1_xa_q   <= r1_xa_d;
            r1_xb_q   <= r1_xb_d;
            r1_tag_q  <= r0_tag_q;
            r2_vld_q  <= r1_vld_q;
            r2_s_q    <= r1_s_q;
            r2_za_q   <= r1_za_q;
            r2_zb_q   <= r1_zb_q;
            r2_kd_q   <= r2_kd_d;
            r2_xd_q   <= r2_xd_d;
            r2_tag_q  <= r1_tag_q;
            out_vld_q <= r2_vld_q;
            out_q_q   <= out_q_d;
            out_dz_q  <= out_dz_d;
            out_tag_q <= r2_tag_q;
        end
    end

endmodule
